// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered or first-word-fall-through read, programmable
// almost-full/almost-empty thresholds, fill level, synchronous flush and sticky error flags.
module sync_fifo_flags #(
  parameter int G_WIDTH  = 8,
  parameter int G_DEPTH  = 4,
  parameter int G_FWFT   = 0,
  parameter int G_AFULL  = 12,
  parameter int G_AEMPTY = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic               i_wr,
  input  logic [G_WIDTH-1:0] i_data,
  input  logic               i_rd,
  input  logic               i_clr_err,
  output logic [G_WIDTH-1:0] o_data,
  output logic               o_valid,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_afull,
  output logic               o_aempty,
  output logic [G_DEPTH:0]   o_fill,
  output logic               o_overflow,
  output logic               o_underflow
);

  localparam int NWORDS = 2 ** G_DEPTH;
  localparam logic [G_DEPTH:0] C_FULL   = (G_DEPTH + 1)'(NWORDS);
  localparam logic [G_DEPTH:0] C_AFULL  = (G_DEPTH + 1)'(G_AFULL);
  localparam logic [G_DEPTH:0] C_AEMPTY = (G_DEPTH + 1)'(G_AEMPTY);
  localparam logic [G_DEPTH:0] C_ONE    = (G_DEPTH + 1)'(1);

  logic [G_WIDTH-1:0] mem_q [NWORDS];

  logic [G_DEPTH:0] wr_ptr_q, wr_ptr_d;
  logic [G_DEPTH:0] rd_ptr_q, rd_ptr_d;
  logic [G_DEPTH:0] fill_q, fill_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic full, empty;
  logic rd_ok, wr_ok;
  logic rd_go, wr_go;

  assign full  = (fill_q == C_FULL);
  assign empty = (fill_q == '0);

  // Acceptance is judged without flush so errors are computed on the raw request;
  // flush then vetoes the actual pointer/memory update.
  assign rd_ok = i_rd && !empty;
  assign wr_ok = i_wr && (!full || rd_ok);
  assign rd_go = rd_ok && !i_flush;
  assign wr_go = wr_ok && !i_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (wr_go) wr_ptr_d = wr_ptr_q + C_ONE;
      if (rd_go) rd_ptr_d = rd_ptr_q + C_ONE;
      case ({wr_go, rd_go})
        2'b10:   fill_d = fill_q + C_ONE;
        2'b01:   fill_d = fill_q - C_ONE;
        default: fill_d = fill_q;
      endcase
    end

    if (i_clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    // Set after clear so a same-cycle error wins over the clear.
    if (!i_flush && i_wr && !wr_ok) ovf_d = 1'b1;
    if (!i_flush && i_rd && !rd_ok) udf_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_go) mem_q[wr_ptr_q[G_DEPTH-1:0]] <= i_data;
  end

  generate
    if (G_FWFT != 0) begin : g_fwft
      // Head word is shown whenever the FIFO holds data; forced to zero when empty.
      assign o_data  = empty ? '0 : mem_q[rd_ptr_q[G_DEPTH-1:0]];
      assign o_valid = !empty;
    end else begin : g_std
      logic [G_WIDTH-1:0] data_q;
      logic               vld_q;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          data_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          vld_q <= rd_go;
          if (rd_go) data_q <= mem_q[rd_ptr_q[G_DEPTH-1:0]];
        end
      end

      assign o_data  = data_q;
      assign o_valid = vld_q;
    end
  endgenerate

  assign o_full      = full;
  assign o_empty     = empty;
  assign o_afull     = (fill_q >= C_AFULL);
  assign o_aempty    = (fill_q <= C_AEMPTY);
  assign o_fill      = fill_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = udf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: one standard-mode and one FWFT instance,
// checked with immediate assertions against hand-computed values.
module tb_sync_fifo_flags;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       s_flush = 0, s_wr = 0, s_rd = 0, s_clr = 0;
  logic [7:0] s_din = '0;
  logic [7:0] s_data;
  logic       s_valid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
  logic [4:0] s_fill;

  logic       f_flush = 0, f_wr = 0, f_rd = 0, f_clr = 0;
  logic [7:0] f_din = '0;
  logic [7:0] f_data;
  logic       f_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
  logic [4:0] f_fill;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.G_WIDTH(8), .G_DEPTH(4), .G_FWFT(0), .G_AFULL(12), .G_AEMPTY(4)) u_std (
    .i_clk(clk), .i_rst(rst), .i_flush(s_flush), .i_wr(s_wr), .i_data(s_din),
    .i_rd(s_rd), .i_clr_err(s_clr), .o_data(s_data), .o_valid(s_valid),
    .o_full(s_full), .o_empty(s_empty), .o_afull(s_afull), .o_aempty(s_aempty),
    .o_fill(s_fill), .o_overflow(s_ovf), .o_underflow(s_udf)
  );

  sync_fifo_flags #(.G_WIDTH(8), .G_DEPTH(4), .G_FWFT(1), .G_AFULL(12), .G_AEMPTY(4)) u_fw (
    .i_clk(clk), .i_rst(rst), .i_flush(f_flush), .i_wr(f_wr), .i_data(f_din),
    .i_rd(f_rd), .i_clr_err(f_clr), .o_data(f_data), .o_valid(f_valid),
    .o_full(f_full), .o_empty(f_empty), .o_afull(f_afull), .o_aempty(f_aempty),
    .o_fill(f_fill), .o_overflow(f_ovf), .o_underflow(f_udf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic s_cyc(input logic wr, input logic [7:0] d, input logic rd,
                       input logic fl, input logic clr);
    s_wr = wr; s_din = d; s_rd = rd; s_flush = fl; s_clr = clr;
    @(posedge clk);
    #1;
    s_wr = 0; s_rd = 0; s_flush = 0; s_clr = 0;
  endtask

  task automatic f_cyc(input logic wr, input logic [7:0] d, input logic rd);
    f_wr = wr; f_din = d; f_rd = rd;
    @(posedge clk);
    #1;
    f_wr = 0; f_rd = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Reset state
    chk("rst_fill", s_fill, 0);
    chk("rst_empty", s_empty, 1);
    chk("rst_full", s_full, 0);
    chk("rst_aempty", s_aempty, 1);
    chk("rst_afull", s_afull, 0);
    chk("rst_valid", s_valid, 0);
    chk("rst_data", s_data, 8'h00);
    chk("rst_ovf", s_ovf, 0);
    chk("rst_udf", s_udf, 0);
    chk("rst_fw_valid", f_valid, 0);

    // 1: fill with 0x00..0x0F, then an overflowing write
    for (int i = 0; i < 16; i++) begin
      s_cyc(1, 8'(i), 0, 0, 0);
      chk("t1_fill", s_fill, i + 1);
      chk("t1_afull", s_afull, (i + 1) >= 12);
      chk("t1_aempty", s_aempty, (i + 1) <= 4);
      chk("t1_full", s_full, (i + 1) == 16);
      chk("t1_empty", s_empty, 0);
    end
    chk("t1_ovf_before", s_ovf, 0);
    s_cyc(1, 8'hFF, 0, 0, 0);
    chk("t1_ovf", s_ovf, 1);
    chk("t1_fill16", s_fill, 16);
    s_cyc(0, 8'h00, 0, 0, 0);
    chk("t1_ovf_sticky", s_ovf, 1);

    // 2: drain in standard mode, then an underflowing read and error clear
    for (int i = 0; i < 16; i++) begin
      s_cyc(0, 8'h00, 1, 0, 0);
      chk("t2_valid", s_valid, 1);
      chk("t2_data", s_data, i);
      chk("t2_fill", s_fill, 15 - i);
    end
    chk("t2_empty", s_empty, 1);
    s_cyc(0, 8'h00, 0, 0, 0);
    chk("t2_valid_pulse", s_valid, 0);
    chk("t2_data_hold", s_data, 8'h0F);
    s_cyc(0, 8'h00, 1, 0, 0);
    chk("t2_udf", s_udf, 1);
    chk("t2_udf_novalid", s_valid, 0);
    s_cyc(0, 8'h00, 0, 0, 1);
    chk("t2_udf_clr", s_udf, 0);
    chk("t2_ovf_clr", s_ovf, 0);

    // 3: full FIFO with simultaneous read/write across pointer wrap
    for (int i = 0; i < 16; i++) s_cyc(1, 8'(i), 0, 0, 0);
    chk("t3_full", s_full, 1);
    for (int k = 0; k < 40; k++) begin
      s_cyc(1, 8'(16 + k), 1, 0, 0);
      chk("t3_valid", s_valid, 1);
      chk("t3_data", s_data, k);
      chk("t3_fill", s_fill, 16);
      chk("t3_ovf", s_ovf, 0);
    end
    for (int k = 0; k < 16; k++) begin
      s_cyc(0, 8'h00, 1, 0, 0);
      chk("t3_drain", s_data, 40 + k);
    end
    chk("t3_empty", s_empty, 1);
    chk("t3_udf", s_udf, 0);

    // 4: FWFT fall-through and pop
    chk("t4_pre_empty", f_empty, 1);
    f_cyc(1, 8'hA5, 0);
    chk("t4_valid", f_valid, 1);
    chk("t4_data", f_data, 8'hA5);
    f_cyc(0, 8'h00, 0);
    chk("t4_hold", f_data, 8'hA5);
    chk("t4_hold_valid", f_valid, 1);
    f_cyc(0, 8'h00, 1);
    chk("t4_pop_empty", f_empty, 1);
    chk("t4_pop_valid", f_valid, 0);
    f_cyc(1, 8'hB1, 0);
    f_cyc(1, 8'hB2, 0);
    chk("t4_head", f_data, 8'hB1);
    f_cyc(0, 8'h00, 1);
    chk("t4_next", f_data, 8'hB2);
    chk("t4_fill", f_fill, 1);

    // 5: flush overrides write and read; sticky flags untouched
    s_cyc(0, 8'h00, 1, 0, 0);
    chk("t5_udf_set", s_udf, 1);
    for (int i = 0; i < 11; i++) s_cyc(1, 8'(8'h50 + i), 0, 0, 0);
    s_cyc(0, 8'h00, 1, 0, 0);
    chk("t5_fill10", s_fill, 10);
    chk("t5_valid_pre", s_valid, 1);
    s_cyc(1, 8'hEE, 1, 1, 0);
    chk("t5_fill", s_fill, 0);
    chk("t5_empty", s_empty, 1);
    chk("t5_aempty", s_aempty, 1);
    chk("t5_valid", s_valid, 0);
    chk("t5_udf", s_udf, 1);
    chk("t5_ovf", s_ovf, 0);
    s_cyc(1, 8'h77, 0, 0, 0);
    s_cyc(0, 8'h00, 1, 0, 0);
    chk("t5_after", s_data, 8'h77);

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 7; i++) s_cyc(1, 8'(8'h30 + i), 0, 0, 0);
    chk("t6_fill7", s_fill, 7);
    #3 rst = 1;
    #1;
    chk("t6_fill", s_fill, 0);
    chk("t6_empty", s_empty, 1);
    chk("t6_aempty", s_aempty, 1);
    chk("t6_data", s_data, 8'h00);
    chk("t6_udf", s_udf, 0);
    chk("t6_valid", s_valid, 0);
    @(posedge clk);
    #1 rst = 0;
    s_cyc(1, 8'hC3, 0, 0, 0);
    s_cyc(1, 8'hC4, 0, 0, 0);
    s_cyc(0, 8'h00, 1, 0, 0);
    chk("t6_first", s_data, 8'hC3);
    chk("t6_fill_after", s_fill, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
